// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard of in-flight GPR writes for the E..W tail pipeline.
// Produces the D-stage stall and per-operand forward selects, tracks MDU busy latency
// and pending CP0 EPC writes so that ERET waits for them to drain.
// Optional build macro HAZARD_PERF_CNT_EN adds stall performance counters.
module hazard_scoreboard #(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned TNEW_W     = 2,
   parameter int unsigned MDU_LAT    = 5,
   parameter int unsigned SEL_W      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d_valid,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [TNEW_W-1:0] d_tuse_rs,
   input  logic [TNEW_W-1:0] d_tuse_rt,
   input  logic              d_wr_en,
   input  logic [REG_AW-1:0] d_wr_addr,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic              d_mdu_use,
   input  logic [1:0]        d_mdu_start,
   input  logic              d_eret,
   input  logic              d_mtc0_epc,
   input  logic              flush,
   output logic              stall,
   output logic [SEL_W-1:0]  fwd_rs,
   output logic [SEL_W-1:0]  fwd_rt,
   output logic              mdu_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_mdu_stall_cyc
`endif
);

   localparam int unsigned CNT_W = $clog2(2 * MDU_LAT + 1);

   logic [NUM_STAGES-1:0] valid_q, valid_d;
   // epc marks a real instruction that writes EPC; it does not depend on a GPR write
   logic [NUM_STAGES-1:0] epc_q, epc_d;
   logic [REG_AW-1:0]     addr_q [NUM_STAGES];
   logic [REG_AW-1:0]     addr_d [NUM_STAGES];
   logic [TNEW_W-1:0]     tnew_q [NUM_STAGES];
   logic [TNEW_W-1:0]     tnew_d [NUM_STAGES];
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic              rs_hit, rt_hit;
   logic [TNEW_W-1:0] rs_tnew, rt_tnew;
   logic [SEL_W-1:0]  rs_sel, rt_sel;
   logic              gpr_hazard, mdu_term, eret_term, advance;

   assign mdu_busy = (cnt_q != '0);

   // Youngest-match lookup: scan oldest to youngest so the lowest index wins.
   always_comb begin
      rs_hit  = 1'b0;
      rs_tnew = '0;
      rs_sel  = '0;
      rt_hit  = 1'b0;
      rt_tnew = '0;
      rt_sel  = '0;
      for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
         if (valid_q[i] && (addr_q[i] == d_rs)) begin
            rs_hit  = 1'b1;
            rs_tnew = tnew_q[i];
            rs_sel  = SEL_W'(i + 1);
         end
         if (valid_q[i] && (addr_q[i] == d_rt)) begin
            rt_hit  = 1'b1;
            rt_tnew = tnew_q[i];
            rt_sel  = SEL_W'(i + 1);
         end
      end
   end

   // Stall and forward decisions from the matched entries and MDU/EPC state.
   always_comb begin
      gpr_hazard = ((d_rs != '0) && rs_hit && (rs_tnew > d_tuse_rs)) ||
                   ((d_rt != '0) && rt_hit && (rt_tnew > d_tuse_rt));
      mdu_term   = d_valid && d_mdu_use && mdu_busy;
      eret_term  = d_eret && (|epc_q);
      stall      = gpr_hazard || mdu_term || eret_term;
      fwd_rs     = ((d_rs != '0) && rs_hit && (rs_tnew == '0)) ? rs_sel : '0;
      fwd_rt     = ((d_rt != '0) && rt_hit && (rt_tnew == '0)) ? rt_sel : '0;
      advance    = d_valid && !stall && !flush;
   end

   // Next state: shift entries down the pipe, age Tnew, capture D or a bubble.
   always_comb begin
      valid_d[0] = advance && d_wr_en && (d_wr_addr != '0);
      epc_d[0]   = advance && d_mtc0_epc;
      addr_d[0]  = d_wr_addr;
      tnew_d[0]  = d_tnew;
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
         valid_d[i] = valid_q[i-1];
         epc_d[i]   = epc_q[i-1];
         addr_d[i]  = addr_q[i-1];
         tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TNEW_W'(1);
      end
      if (flush) begin
         valid_d = '0;
         epc_d   = '0;
      end

      // An issued MDU op always completes; flush leaves the counter alone.
      if (advance && (d_mdu_start == 2'b01)) begin
         cnt_d = CNT_W'(MDU_LAT);
      end else if (advance && (d_mdu_start == 2'b10)) begin
         cnt_d = CNT_W'(2 * MDU_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Scoreboard and MDU counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         epc_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < int'(NUM_STAGES); i++) begin
            addr_q[i] <= '0;
            tnew_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         tnew_q  <= tnew_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Free-running stall counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cyc     <= '0;
         perf_mdu_stall_cyc <= '0;
      end else begin
         if (stall) perf_stall_cyc <= perf_stall_cyc + 32'd1;
         if (mdu_term && !gpr_hazard && !eret_term) begin
            perf_mdu_stall_cyc <= perf_mdu_stall_cyc + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table, reset/perf sequences and
// randomized stimulus checked against a queue-based reference model.
module tb_hazard_scoreboard;

   localparam int NS  = 3;
   localparam int AW  = 5;
   localparam int TW  = 2;
   localparam int LAT = 5;
   localparam int SW  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          d_valid, d_wr_en, d_mdu_use, d_eret, d_mtc0_epc, flush;
   logic [AW-1:0] d_rs, d_rt, d_wr_addr;
   logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic [1:0]    d_mdu_start;
   logic          stall, mdu_busy;
   logic [SW-1:0] fwd_rs, fwd_rt;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   perf_stall_cyc, perf_mdu_stall_cyc;
`endif

   hazard_scoreboard #(
      .NUM_STAGES(NS), .REG_AW(AW), .TNEW_W(TW), .MDU_LAT(LAT), .SEL_W(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr_en(d_wr_en),
      .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_mdu_use(d_mdu_use),
      .d_mdu_start(d_mdu_start), .d_eret(d_eret), .d_mtc0_epc(d_mtc0_epc),
      .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
      .mdu_busy(mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cyc(perf_stall_cyc), .perf_mdu_stall_cyc(perf_mdu_stall_cyc)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One D-stage cycle: inputs plus expected combinational outputs.
   typedef struct {
      int v, rs, rt, urs, urt, we, wa, tn, mu, ms, er, ep, fl;
      int xs, xfs, xfr, xb;
   } vec_t;

   function automatic vec_t mk(input int v, rs, rt, urs, urt, we, wa, tn, mu, ms, er, ep,
                               fl, xs, xfs, xfr, xb);
      vec_t t;
      t.v = v;   t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.we = we; t.wa = wa;
      t.tn = tn; t.mu = mu; t.ms = ms; t.er = er;   t.ep = ep;   t.fl = fl;
      t.xs = xs; t.xfs = xfs; t.xfr = xfr; t.xb = xb;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      d_valid     = (t.v != 0);
      d_rs        = AW'(t.rs);
      d_rt        = AW'(t.rt);
      d_tuse_rs   = TW'(t.urs);
      d_tuse_rt   = TW'(t.urt);
      d_wr_en     = (t.we != 0);
      d_wr_addr   = AW'(t.wa);
      d_tnew      = TW'(t.tn);
      d_mdu_use   = (t.mu != 0);
      d_mdu_start = 2'(t.ms);
      d_eret      = (t.er != 0);
      d_mtc0_epc  = (t.ep != 0);
      flush       = (t.fl != 0);
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic apply(input vec_t t, input string nm);
      drive(t);
      @(negedge clk);
      check({nm, " stall"},  int'(stall),    t.xs);
      check({nm, " fwd_rs"}, int'(fwd_rs),   t.xfs);
      check({nm, " fwd_rt"}, int'(fwd_rt),   t.xfr);
      check({nm, " busy"},   int'(mdu_busy), t.xb);
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Each in-flight instruction remembers the cycle it entered E; its stage is its age.
   typedef struct {
      int addr;
      int tnew0;
      bit epc;
      int birth;
   } inflight_t;

   inflight_t mq[$];   // front = youngest
   int        cyc      = 0;
   int        mdu_done = 0;

   function automatic void model_reset();
      mq.delete();
      mdu_done = cyc;
   endfunction

   function automatic void lookup(input int a, input int tuse, output bit hz, output int sel);
      hz  = 1'b0;
      sel = 0;
      if (a == 0) return;
      foreach (mq[j]) begin
         int age = cyc - mq[j].birth;
         int rem = (mq[j].tnew0 > age) ? mq[j].tnew0 - age : 0;
         if (mq[j].addr == a) begin
            if (rem == 0) sel = age + 1;
            else if (rem > tuse) hz = 1'b1;
            return;
         end
      end
   endfunction

   function automatic void model_eval(output bit s, output int frs, output int frt,
                                      output bit busy);
      bit hrs, hrt;
      bit epc_any = 1'b0;
      lookup(int'(d_rs), int'(d_tuse_rs), hrs, frs);
      lookup(int'(d_rt), int'(d_tuse_rt), hrt, frt);
      busy = (cyc < mdu_done);
      foreach (mq[j]) if (mq[j].epc) epc_any = 1'b1;
      s = hrs || hrt || (d_valid && d_mdu_use && busy) || (d_eret && epc_any);
   endfunction

   function automatic void model_edge(input bit s);
      bit        adv = d_valid && !s && !flush;
      inflight_t e;
      cyc++;
      if (flush) begin
         mq.delete();
      end else if (adv) begin
         e.addr  = (d_wr_en && d_wr_addr != 0) ? int'(d_wr_addr) : 0;
         e.tnew0 = int'(d_tnew);
         e.epc   = d_mtc0_epc;
         e.birth = cyc;
         mq.push_front(e);
      end
      while (mq.size() > 0 && (cyc - mq[$].birth) >= NS) void'(mq.pop_back());
      if (adv && d_mdu_start == 2'b01) mdu_done = cyc + LAT;
      else if (adv && d_mdu_start == 2'b10) mdu_done = cyc + 2 * LAT;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   vec_t seq[$];

   initial begin
      rst_n = 1'b0;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
      #3;
      check("reset stall",  int'(stall),    0);
      check("reset fwd_rs", int'(fwd_rs),   0);
      check("reset fwd_rt", int'(fwd_rt),   0);
      check("reset busy",   int'(mdu_busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---- directed table ----
      //                v rs rt ur ut we wa tn mu ms er ep fl   xs xfs xfr xb
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // lw $3
      tbl.push_back(mk(1, 3, 3, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0)); // add: load-use
      tbl.push_back(mk(1, 3, 3, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 3, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0,  0, 3, 3, 0)); // from W
      tbl.push_back(mk(1, 4, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0)); // ALU chain
      tbl.push_back(mk(1, 4, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0,  0, 2, 0, 0)); // from M
      tbl.push_back(mk(1, 4, 7, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0)); // tnew<=tuse
      tbl.push_back(mk(1, 7, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0));
      tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0));
      tbl.push_back(mk(0, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 0)); // youngest wins
      tbl.push_back(mk(1, 6, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0,  0, 3, 0, 0)); // write $0
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0)); // mult
      for (int i = 0; i < LAT; i++)
         tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1)); // mflo
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0)); // div
      for (int i = 0; i < 2 * LAT; i++)
         tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1)); // mfhi
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0)); // mtc0 EPC
      for (int i = 0; i < NS; i++)
         tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0)); // eret
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0)); // mtc0 EPC
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0)); // eret+flush
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // lw $9
      tbl.push_back(mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0)); // flush
      tbl.push_back(mk(1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // ---- async reset mid-stall ----
      do_reset();
      apply(mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0), "ar_a");
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0), "ar_b");
      apply(mk(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0,  0, 0, 0, 1), "ar_c");
      drive(mk(1, 3, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));
      @(negedge clk);
      check("ar pre stall",  int'(stall),    1);
      check("ar pre fwd_rt", int'(fwd_rt),   3);
      check("ar pre busy",   int'(mdu_busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar stall",  int'(stall),    0);
      check("ar fwd_rs", int'(fwd_rs),   0);
      check("ar fwd_rt", int'(fwd_rt),   0);
      check("ar busy",   int'(mdu_busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

`ifdef HAZARD_PERF_CNT_EN
      // ---- perf counters: 2 GPR stalls + 5 MDU-only stalls ----
      do_reset();
      seq.push_back(mk(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      seq.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
      seq.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
      seq.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 3, 0));
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
      for (int i = 0; i < LAT; i++)
         seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1));
      seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));
      foreach (seq[i]) apply(seq[i], $sformatf("perf[%0d]", i));
      check("perf_stall_cyc",     int'(perf_stall_cyc),     7);
      check("perf_mdu_stall_cyc", int'(perf_mdu_stall_cyc), LAT);
`endif

      // ---- randomized against the reference model ----
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit es, eb;
         int efs, efr;
         d_valid     = ($urandom_range(0, 9) < 8);
         d_rs        = AW'($urandom_range(0, 3));
         d_rt        = AW'($urandom_range(0, 3));
         d_tuse_rs   = TW'($urandom_range(0, 3));
         d_tuse_rt   = TW'($urandom_range(0, 3));
         d_wr_en     = ($urandom_range(0, 3) != 0);
         d_wr_addr   = AW'($urandom_range(0, 3));
         d_tnew      = TW'($urandom_range(0, 3));
         d_mdu_use   = ($urandom_range(0, 19) < 3);
         d_mdu_start = d_mdu_use ? 2'($urandom_range(0, 2)) : 2'b00;
         d_eret      = ($urandom_range(0, 19) == 0);
         d_mtc0_epc  = ($urandom_range(0, 19) == 0);
         flush       = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         model_eval(es, efs, efr, eb);
         check("rnd stall",  int'(stall),    int'(es));
         check("rnd fwd_rs", int'(fwd_rs),   efs);
         check("rnd fwd_rt", int'(fwd_rt),   efr);
         check("rnd busy",   int'(mdu_busy), int'(eb));
         model_edge(es);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
